// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central pipeline controller for the 5-stage core. Produces the stall/bubble
//   controls for every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//   It resolves three hazards, highest priority first:
//     1. data memory busy   -> freeze the pipe and drain a bubble into WB
//     2. EX-stage redirect  -> squash the two younger instructions
//     3. load-use           -> hold IF/ID for one cycle and bubble EX
//   A small FSM (RUN / MEM_WAIT / HALT) tracks the memory wait. A saturating
//   counter bounds the wait, and a sticky timeout flag parks the core in HALT
//   until reset.
//
// Configuration macro: PIPE_PERF_EN
//   When defined, two free-running 32-bit performance counters are built:
//   stall cycles (stall_if=1) and redirect flushes. When undefined, both
//   outputs are tied to zero and no counter registers exist.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_rs1_id, i_rs2_id         source registers of the ID instruction
//   i_use_rs1_id, i_use_rs2_id ID instruction actually reads rs1 / rs2
//   i_rd_ex, i_mem_read_ex     destination and load flag of the EX instruction
//   i_jump_ex                  EX resolved a taken branch/jump this cycle
//   i_mem_req_mem, i_mem_ready MEM-stage data access and its completion
//   o_stall_* / o_bubble_*     per-register hold / insert-bubble controls
//   o_mem_timeout              sticky; a memory access waited past WAIT_MAX
//   o_perf_stall_cnt           stall-cycle count (0 without PIPE_PERF_EN)
//   o_perf_flush_cnt           redirect-flush count (0 without PIPE_PERF_EN)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_id,
    input  logic [4:0]  i_rs2_id,
    input  logic        i_use_rs1_id,
    input  logic        i_use_rs2_id,
    input  logic [4:0]  i_rd_ex,
    input  logic        i_mem_read_ex,
    input  logic        i_jump_ex,
    input  logic        i_mem_req_mem,
    input  logic        i_mem_ready,
    output logic        o_stall_if,
    output logic        o_stall_id,
    output logic        o_bubble_id,
    output logic        o_stall_ex,
    output logic        o_bubble_ex,
    output logic        o_stall_mem,
    output logic        o_bubble_mem,
    output logic        o_stall_wb,
    output logic        o_bubble_wb,
    output logic        o_mem_timeout,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_flush_cnt
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_mem_timeout;
    logic             w_timeout_nxt;

    logic w_hold;       // memory-stall response is active this cycle
    logic w_load_use;
    logic w_redirect;
    logic w_lu_stall;

    // Raw load-use match; x0 is never a real dependency.
    assign w_load_use = i_mem_read_ex && (i_rd_ex != 5'd0) &&
                        ((i_use_rs1_id && (i_rs1_id == i_rd_ex)) ||
                         (i_use_rs2_id && (i_rs2_id == i_rd_ex)));

    // Next-state logic. w_hold selects the memory-freeze output pattern; when
    // it is clear the hazard rules below decide the outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_mem_timeout;
        w_hold         = 1'b0;

        if (!i_rst) begin
            case (r_state)
                S_RUN: begin
                    if (i_mem_req_mem && !i_mem_ready) begin
                        w_hold         = 1'b1;
                        w_state_nxt    = S_MEM_WAIT;
                        w_wait_cnt_nxt = CNT_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        // Release cycle: hazard rules apply now so MEM/WB
                        // captures the returned data.
                        w_state_nxt    = S_RUN;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_hold = 1'b1;
                        if (r_wait_cnt == CNT_MAX) begin
                            w_timeout_nxt = 1'b1;
                            w_state_nxt   = S_HALT;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
                        end
                    end
                end
                S_HALT: begin
                    w_hold = 1'b1;
                end
                default: begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Redirect beats load-use: the dependent instruction is being squashed
    // anyway, so stalling it would only waste a cycle.
    assign w_redirect = !i_rst && !w_hold && i_jump_ex;
    assign w_lu_stall = !i_rst && !w_hold && !i_jump_ex && w_load_use;

    // Reset forces bubbles everywhere so stale contents are flushed.
    assign o_stall_if    = w_hold | w_lu_stall;
    assign o_stall_id    = w_hold | w_lu_stall;
    assign o_bubble_id   = i_rst | w_redirect;
    assign o_stall_ex    = w_hold;
    assign o_bubble_ex   = i_rst | w_redirect | w_lu_stall;
    assign o_stall_mem   = w_hold;
    assign o_bubble_mem  = i_rst;
    assign o_stall_wb    = 1'b0;
    assign o_bubble_wb   = i_rst | w_hold;
    assign o_mem_timeout = r_mem_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= w_timeout_nxt;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stall_cnt <= 32'd0;
            r_perf_flush_cnt <= 32'd0;
        end else begin
            if (o_stall_if) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`else
    assign o_perf_stall_cnt = 32'd0;
    assign o_perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (WAIT_MAX=4). A behavioural model of
//   the controller (wait-cycle count, halt/timeout flags, perf totals) is
//   checked against the DUT on every falling edge; literal expectations at
//   key points pin the model itself.
//   Output vector bit order:
//   [9]stall_if [8]stall_id [7]bubble_id [6]stall_ex [5]bubble_ex
//   [4]stall_mem [3]bubble_mem [2]stall_wb [1]bubble_wb [0]mem_timeout
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int WMAX = 4;

    localparam logic [9:0] V_RST  = 10'b0010101010;
    localparam logic [9:0] V_MEM  = 10'b1101010010;
    localparam logic [9:0] V_LU   = 10'b1100100000;
    localparam logic [9:0] V_JMP  = 10'b0010100000;
    localparam logic [9:0] V_IDLE = 10'b0000000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        use_rs1_id, use_rs2_id, mem_read_ex, jump_ex;
    logic        mem_req_mem, mem_ready;
    logic        stall_if, stall_id, bubble_id, stall_ex, bubble_ex;
    logic        stall_mem, bubble_mem, stall_wb, bubble_wb, mem_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [9:0]  outv;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_wait  = 0;
    bit m_halt  = 1'b0;
    bit m_to    = 1'b0;
    int m_pstall = 0;
    int m_pflush = 0;

    pipe_hazard_ctrl #(.WAIT_MAX(WMAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
        .i_use_rs1_id(use_rs1_id), .i_use_rs2_id(use_rs2_id),
        .i_rd_ex(rd_ex), .i_mem_read_ex(mem_read_ex), .i_jump_ex(jump_ex),
        .i_mem_req_mem(mem_req_mem), .i_mem_ready(mem_ready),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_id(bubble_id),
        .o_stall_ex(stall_ex), .o_bubble_ex(bubble_ex),
        .o_stall_mem(stall_mem), .o_bubble_mem(bubble_mem),
        .o_stall_wb(stall_wb), .o_bubble_wb(bubble_wb),
        .o_mem_timeout(mem_timeout),
        .o_perf_stall_cnt(perf_stall_cnt), .o_perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    assign outv = {stall_if, stall_id, bubble_id, stall_ex, bubble_ex,
                   stall_mem, bubble_mem, stall_wb, bubble_wb, mem_timeout};

    // Is the memory currently holding the pipe?
    function automatic bit model_mem_hold();
        if (m_halt) return 1'b1;
        if (m_wait > 0) return !mem_ready;
        return mem_req_mem && !mem_ready;
    endfunction

    function automatic logic [9:0] model_out();
        logic [9:0] v;
        bit lu;
        if (rst) return V_RST | {9'd0, m_to};
        if (model_mem_hold()) return V_MEM | {9'd0, m_to};
        lu = mem_read_ex && (rd_ex != 0) &&
             ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
        if (jump_ex)   v = V_JMP;
        else if (lu)   v = V_LU;
        else           v = V_IDLE;
        return v | {9'd0, m_to};
    endfunction

    // Model advances on each rising edge with the inputs of that cycle.
    always @(posedge clk) begin
        logic [9:0] e;
        if (rst) begin
            m_wait = 0; m_halt = 1'b0; m_to = 1'b0;
            m_pstall = 0; m_pflush = 0;
        end else begin
            e = model_out();
            if (e[9]) m_pstall = m_pstall + 1;
            if (!model_mem_hold() && jump_ex) m_pflush = m_pflush + 1;
            if (m_halt) begin
                // only reset leaves HALT
            end else if (model_mem_hold()) begin
                if (m_wait == WMAX) begin
                    m_halt = 1'b1;
                    m_to   = 1'b1;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else begin
                m_wait = 0;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic [9:0]  e;
        logic [31:0] es, ef;
        e = model_out();
`ifdef PIPE_PERF_EN
        es = 32'(m_pstall);
        ef = 32'(m_pflush);
`else
        es = 32'd0;
        ef = 32'd0;
`endif
        n_cmp = n_cmp + 1;
        if (outv !== e) begin
            n_bad = n_bad + 1;
            $display("FAIL model_outputs t=%0t got=%b want=%b", $time, outv, e);
        end
        n_cmp = n_cmp + 1;
        if (perf_stall_cnt !== es || perf_flush_cnt !== ef) begin
            n_bad = n_bad + 1;
            $display("FAIL model_perf t=%0t got=%0d/%0d want=%0d/%0d",
                     $time, perf_stall_cnt, perf_flush_cnt, es, ef);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rs1_id = 0; rs2_id = 0; rd_ex = 0;
        use_rs1_id = 0; use_rs2_id = 0; mem_read_ex = 0; jump_ex = 0;
        mem_req_mem = 0; mem_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clr_in();

        // 1: reset flushes the pipe
        tick(); chk("rst_c1", 32'(outv), 32'(V_RST));
        tick(); chk("rst_c2", 32'(outv), 32'(V_RST));
        rst = 1'b0; #1;
        chk("run_idle", 32'(outv), 32'(V_IDLE));

        // 2: load-use on rs2, then the load moves on to MEM
        tick();
        mem_read_ex = 1; rd_ex = 5; rs2_id = 5; use_rs2_id = 1; #1;
        chk("lu_rs2", 32'(outv), 32'(V_LU));
        tick();
        mem_read_ex = 0; rd_ex = 9; mem_req_mem = 1; mem_ready = 1; #1;
        chk("lu_released", 32'(outv), 32'(V_IDLE));

        // 3: rd_ex = x0 never stalls
        tick(); clr_in();
        mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        use_rs1_id = 1; use_rs2_id = 1; #1;
        chk("lu_x0", 32'(outv), 32'(V_IDLE));
        // rs1 match
        tick(); clr_in();
        mem_read_ex = 1; rd_ex = 7; rs1_id = 7; use_rs1_id = 1; #1;
        chk("lu_rs1", 32'(outv), 32'(V_LU));
        // match but operand not used
        tick(); use_rs1_id = 0; #1;
        chk("lu_unused", 32'(outv), 32'(V_IDLE));
        // not a load
        tick(); use_rs1_id = 1; mem_read_ex = 0; #1;
        chk("lu_notload", 32'(outv), 32'(V_IDLE));
        // redirect beats load-use
        tick(); mem_read_ex = 1; jump_ex = 1; #1;
        chk("jmp_over_lu", 32'(outv), 32'(V_JMP));

        // 4: three wait cycles, released on the fourth
        tick(); clr_in();
        mem_req_mem = 1; mem_ready = 0; #1;
        chk("memw_1", 32'(outv), 32'(V_MEM));
        tick(); chk("memw_2", 32'(outv), 32'(V_MEM));
        tick(); chk("memw_3", 32'(outv), 32'(V_MEM));
        tick(); mem_ready = 1; #1;
        chk("memw_release", 32'(outv), 32'(V_IDLE));
        tick(); mem_req_mem = 0; mem_ready = 0; #1;
        chk("memw_back_run", 32'(outv), 32'(V_IDLE));

        // 5: timeout after the fifth wait cycle
        tick(); mem_req_mem = 1; mem_ready = 0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("to_pending", 32'(outv), 32'(V_MEM));
            tick();
        end
        chk("to_set", 32'(outv), 32'(V_MEM | 10'd1));
        mem_req_mem = 0; mem_ready = 1; jump_ex = 1; #1;
        chk("halt_ignores_ready", 32'(outv), 32'(V_MEM | 10'd1));
        tick(); chk("halt_sticky", 32'(outv), 32'(V_MEM | 10'd1));
        clr_in(); rst = 1'b1;
        tick(); chk("halt_reset", 32'(outv), 32'(V_RST));

        // 6: jump during wait is ignored, honoured at release
        rst = 1'b0; mem_req_mem = 1; mem_ready = 0; jump_ex = 1; #1;
        chk("jmp_in_wait1", 32'(outv), 32'(V_MEM));
        tick(); chk("jmp_in_wait2", 32'(outv), 32'(V_MEM));
        tick(); mem_ready = 1; #1;
        chk("jmp_after_release", 32'(outv), 32'(V_JMP));
        tick();
`ifdef PIPE_PERF_EN
        chk("perf_flush", perf_flush_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd2);
`else
        chk("perf_flush_off", perf_flush_cnt, 32'd0);
        chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
        clr_in(); #1;
        chk("final_idle", 32'(outv), 32'(V_IDLE));
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
